// File: rtl/time_edit_ctrl.sv
// Digit-by-digit HH:MM editor for the set-time and set-alarm modes.
// Loads the current time on edit entry, steps a cursor across the four BCD digits, and acknowledges on completion.
module time_edit_ctrl #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_edit_en,
    input  logic [4:0] i_init_hours,
    input  logic [5:0] i_init_minutes,
    input  logic       i_inc_button,
    input  logic       i_next_button,
    output logic [1:0] o_hours_left,
    output logic [3:0] o_hours_right,
    output logic [2:0] o_minutes_left,
    output logic [3:0] o_minutes_right,
    output logic [4:0] o_hours_bin,
    output logic [5:0] o_minutes_bin,
    output logic [1:0] o_digit_sel,
    output logic       o_blink,
    output logic       o_ack_flag,
    output logic       o_load_pulse
);

    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_HL,
        S_EDIT_HR,
        S_EDIT_ML,
        S_EDIT_MR,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state;
    logic [1:0]       r_hl;
    logic [1:0]       w_hl;
    logic [3:0]       r_hr;
    logic [3:0]       w_hr;
    logic [2:0]       r_ml;
    logic [2:0]       w_ml;
    logic [3:0]       r_mr;
    logic [3:0]       w_mr;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel;
    logic             r_blink;
    logic             w_blink;
    logic             r_ack;
    logic             w_ack;
    logic             r_load;
    logic             w_load;
    logic             r_edit_en_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;

    // Tens/units split by comparison; the ranges are small enough that no divider is needed.
    function automatic logic [1:0] hoursTens(input logic [4:0] value);
        if (value >= 5'd20)
            return 2'd2;
        else if (value >= 5'd10)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] hoursUnits(input logic [4:0] value);
        logic [4:0] units;
        units = value - 5'(hoursTens(value)) * 5'd10;
        return units[3:0];
    endfunction

    function automatic logic [2:0] minutesTens(input logic [5:0] value);
        if (value >= 6'd50)
            return 3'd5;
        else if (value >= 6'd40)
            return 3'd4;
        else if (value >= 6'd30)
            return 3'd3;
        else if (value >= 6'd20)
            return 3'd2;
        else if (value >= 6'd10)
            return 3'd1;
        else
            return 3'd0;
    endfunction

    function automatic logic [3:0] minutesUnits(input logic [5:0] value);
        logic [5:0] units;
        units = value - 6'(minutesTens(value)) * 6'd10;
        return units[3:0];
    endfunction

    always_comb begin
        w_state = r_state;
        w_hl    = r_hl;
        w_hr    = r_hr;
        w_ml    = r_ml;
        w_mr    = r_mr;
        w_cnt   = '0;
        w_blink = 1'b0;
        w_ack   = 1'b0;
        w_load  = 1'b0;

        if (!i_edit_en) begin
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_edit_en_d) begin
                        w_state = S_EDIT_HL;
                        if (i_init_hours > 5'd23 || i_init_minutes > 6'd59) begin
                            w_hl = 2'd0;
                            w_hr = 4'd0;
                            w_ml = 3'd0;
                            w_mr = 4'd0;
                        end else begin
                            w_hl = hoursTens(i_init_hours);
                            w_hr = hoursUnits(i_init_hours);
                            w_ml = minutesTens(i_init_minutes);
                            w_mr = minutesUnits(i_init_minutes);
                        end
                    end
                end

                S_EDIT_HL, S_EDIT_HR, S_EDIT_ML, S_EDIT_MR: begin
                    if (i_next_button) begin
                        case (r_state)
                            S_EDIT_HL: w_state = S_EDIT_HR;
                            S_EDIT_HR: w_state = S_EDIT_ML;
                            S_EDIT_ML: w_state = S_EDIT_MR;
                            default: begin
                                w_state = S_DONE;
                                w_ack   = 1'b1;
                                w_load  = 1'b1;
                            end
                        endcase
                    end else begin
                        if (r_cnt == CNT_MAX) begin
                            w_cnt   = '0;
                            w_blink = ~r_blink;
                        end else begin
                            w_cnt   = r_cnt + 1'b1;
                            w_blink = r_blink;
                        end

                        // HR is clamped when HL reaches 2 so the hours never exceed 23.
                        if (i_inc_button) begin
                            case (r_state)
                                S_EDIT_HL: begin
                                    if (r_hl == 2'd2) begin
                                        w_hl = 2'd0;
                                    end else begin
                                        w_hl = r_hl + 2'd1;
                                        if (r_hl == 2'd1 && r_hr > 4'd3)
                                            w_hr = 4'd3;
                                    end
                                end
                                S_EDIT_HR: begin
                                    if ((r_hl == 2'd2 && r_hr >= 4'd3) || r_hr == 4'd9)
                                        w_hr = 4'd0;
                                    else
                                        w_hr = r_hr + 4'd1;
                                end
                                S_EDIT_ML: begin
                                    if (r_ml == 3'd5)
                                        w_ml = 3'd0;
                                    else
                                        w_ml = r_ml + 3'd1;
                                end
                                default: begin
                                    if (r_mr == 4'd9)
                                        w_mr = 4'd0;
                                    else
                                        w_mr = r_mr + 4'd1;
                                end
                            endcase
                        end
                    end
                end

                S_DONE: begin
                    if (i_next_button)
                        w_state = S_EDIT_HL;
                    else
                        w_ack = 1'b1;
                end

                default: w_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sel = 2'd0;
        case (w_state)
            S_EDIT_HR: w_sel = 2'd1;
            S_EDIT_ML: w_sel = 2'd2;
            S_EDIT_MR: w_sel = 2'd3;
            default:   w_sel = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_hl        <= 2'd0;
            r_hr        <= 4'd0;
            r_ml        <= 3'd0;
            r_mr        <= 4'd0;
            r_sel       <= 2'd0;
            r_blink     <= 1'b0;
            r_ack       <= 1'b0;
            r_load      <= 1'b0;
            r_edit_en_d <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state;
            r_hl        <= w_hl;
            r_hr        <= w_hr;
            r_ml        <= w_ml;
            r_mr        <= w_mr;
            r_sel       <= w_sel;
            r_blink     <= w_blink;
            r_ack       <= w_ack;
            r_load      <= w_load;
            r_edit_en_d <= i_edit_en;
            r_cnt       <= w_cnt;
        end
    end

    assign o_hours_left    = r_hl;
    assign o_hours_right   = r_hr;
    assign o_minutes_left  = r_ml;
    assign o_minutes_right = r_mr;
    assign o_hours_bin     = 5'(r_hl) * 5'd10 + 5'(r_hr);
    assign o_minutes_bin   = 6'(r_ml) * 6'd10 + 6'(r_mr);
    assign o_digit_sel     = r_sel;
    assign o_blink         = r_blink;
    assign o_ack_flag      = r_ack;
    assign o_load_pulse    = r_load;

endmodule

// File: tb/tb_time_edit_ctrl.sv
// Scoreboard bench for time_edit_ctrl: directed stimulus queues the expected outputs
// for the following cycle, and an independent monitor compares them on the falling edge.
module tb_time_edit_ctrl;

    localparam int BLINK_DIV = 4;

    typedef struct {
        int    cyc;
        string name;
        int    hl;
        int    hr;
        int    ml;
        int    mr;
        int    sel;
        int    blink;
        int    ack;
        int    load;
    } expect_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       editEn;
    logic       incButton;
    logic       nextButton;
    logic [4:0] initHours;
    logic [5:0] initMinutes;
    logic [1:0] hoursLeft;
    logic [3:0] hoursRight;
    logic [2:0] minutesLeft;
    logic [3:0] minutesRight;
    logic [4:0] hoursBin;
    logic [5:0] minutesBin;
    logic [1:0] digitSel;
    logic       blink;
    logic       ackFlag;
    logic       loadPulse;

    int      cycCount    = 0;
    int      vectors     = 0;
    int      miscompares = 0;
    expect_t expQ[$];

    time_edit_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
        .i_clk          (clock),
        .i_rst          (reset),
        .i_edit_en      (editEn),
        .i_init_hours   (initHours),
        .i_init_minutes (initMinutes),
        .i_inc_button   (incButton),
        .i_next_button  (nextButton),
        .o_hours_left   (hoursLeft),
        .o_hours_right  (hoursRight),
        .o_minutes_left (minutesLeft),
        .o_minutes_right(minutesRight),
        .o_hours_bin    (hoursBin),
        .o_minutes_bin  (minutesBin),
        .o_digit_sel    (digitSel),
        .o_blink        (blink),
        .o_ack_flag     (ackFlag),
        .o_load_pulse   (loadPulse)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycCount++;

    // Queue the outputs expected right after the next rising edge.
    task automatic expectOut(input string name, input int hl, input int hr, input int ml, input int mr,
                             input int sel, input int bl, input int ack, input int load);
        expect_t e;
        e.cyc   = cycCount + 1;
        e.name  = name;
        e.hl    = hl;
        e.hr    = hr;
        e.ml    = ml;
        e.mr    = mr;
        e.sel   = sel;
        e.blink = bl;
        e.ack   = ack;
        e.load  = load;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic en, input logic inc, input logic nxt);
        editEn     = en;
        incButton  = inc;
        nextButton = nxt;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input expect_t e);
        int  expHb;
        int  expMb;
        logic ok;
        expHb = e.hl * 10 + e.hr;
        expMb = e.ml * 10 + e.mr;
        ok = (hoursLeft === 2'(e.hl)) && (hoursRight === 4'(e.hr)) &&
             (minutesLeft === 3'(e.ml)) && (minutesRight === 4'(e.mr)) &&
             (hoursBin === 5'(expHb)) && (minutesBin === 6'(expMb)) &&
             (digitSel === 2'(e.sel)) && (blink === 1'(e.blink)) &&
             (ackFlag === 1'(e.ack)) && (loadPulse === 1'(e.load));
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s cyc %0d: got %0d%0d:%0d%0d bin=%0d:%0d sel=%0d blink=%0b ack=%0b load=%0b, expected %0d%0d:%0d%0d bin=%0d:%0d sel=%0d blink=%0d ack=%0d load=%0d",
                     e.name, cycCount, hoursLeft, hoursRight, minutesLeft, minutesRight, hoursBin, minutesBin,
                     digitSel, blink, ackFlag, loadPulse, e.hl, e.hr, e.ml, e.mr, expHb, expMb,
                     e.sel, e.blink, e.ack, e.load);
        end
    endtask

    always @(negedge clock) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cycCount) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset       = 1'b1;
        editEn      = 1'b0;
        incButton   = 1'b0;
        nextButton  = 1'b0;
        initHours   = 5'd0;
        initMinutes = 6'd0;
        @(posedge clock);
        #1;
        expectOut("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Entry load and a held edit_en that must not reload
        initHours = 5'd13; initMinutes = 6'd47;
        expectOut("load_13_47", 1, 3, 4, 7, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        initHours = 5'd5; initMinutes = 6'd5;
        expectOut("held_en_no_reload", 1, 3, 4, 7, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("drop_idle", 1, 3, 4, 7, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // HL to 2 forces HR to 3, then HR wraps 3 -> 0
        initHours = 5'd19; initMinutes = 6'd0;
        expectOut("load_19_00", 1, 9, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("hl_inc_force_hr", 2, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("next_to_hr", 2, 3, 0, 0, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        expectOut("hr_wrap_at_3", 2, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("drop_in_hr_a", 2, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // MR wraps after ten presses, then DONE with a one-cycle load pulse
        initHours = 5'd0; initMinutes = 6'd0;
        expectOut("load_00_00", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            expectOut("cursor_adv", 0, 0, 0, 0, i, 0, 0, 0);
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        for (int i = 1; i <= 10; i++) begin
            expectOut("mr_inc", 0, 0, 0, i % 10, 3, (i / 4) % 2, 0, 0);
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        expectOut("done_ack_load", 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        expectOut("done_load_low", 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("done_inc_ignored", 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("done_next_reedit", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);

        // Simultaneous inc and next in EDIT_ML: the cursor moves and ML is kept
        expectOut("to_hr", 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        expectOut("to_ml", 0, 0, 0, 0, 2, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            expectOut("ml_inc", 0, 0, i, 0, 2, (i / 4) % 2, 0, 0);
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        expectOut("inc_next_same", 0, 0, 5, 0, 3, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        expectOut("drop_in_mr", 0, 0, 5, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Out-of-range init loads 00:00; blink period and restart on next
        initHours = 5'd25; initMinutes = 6'd70;
        expectOut("load_invalid", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            expectOut("blink_hl", 0, 0, 0, 0, 0, (j / 4) % 2, 0, 0);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        expectOut("blink_restart", 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int j = 1; j <= 5; j++) begin
            expectOut("blink_hr", 0, 0, 0, 0, 1, (j / 4) % 2, 0, 0);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        expectOut("hr_inc", 0, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("drop_in_hr_b", 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectOut("idle_inc_ignored", 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Hours alone out of range still clears both fields
        initHours = 5'd24; initMinutes = 6'd15;
        expectOut("hours_invalid", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("drop_after_invalid", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Upper bound load and HL wrap 2 -> 0 -> 1 -> 2 with HR already 3
        initHours = 5'd23; initMinutes = 6'd59;
        expectOut("load_23_59", 2, 3, 5, 9, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("hl_wrap", 0, 3, 5, 9, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("hl_to_1", 1, 3, 5, 9, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("hl_to_2", 2, 3, 5, 9, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        // Walk to DONE, reset there, then reload from the still-high edit_en
        for (int i = 1; i <= 3; i++) begin
            expectOut("walk", 2, 3, 5, 9, i, 0, 0, 0);
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        expectOut("done_23_59", 2, 3, 5, 9, 0, 0, 1, 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        expectOut("reset_in_done", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        initHours = 5'd12; initMinutes = 6'd34;
        expectOut("reload_after_reset", 1, 2, 3, 4, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        while (expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: expectation never checked (queued for cyc %0d, now %0d)",
                     e.name, e.cyc, cycCount);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_edit_ctrl.md
# time_edit_ctrl

Digit-by-digit editing controller for the clock's set-time and set-alarm modes. When the mode FSM enables editing, it loads the current time, walks a cursor across the four BCD digits (hours-tens, hours-units, minutes-tens, minutes-units) and applies increment presses under 24-hour limits. It then raises the acknowledge flag that the mode FSM requires before leaving the mode. Its digit outputs drive the `*_hours_left/right` and `*_minutes_left/right` inputs of the mode FSM and the timekeeping load path.

## Interface
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; minimum 2.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- edit_en  in  1  high while the mode FSM is in set_time or alarm_mode
- init_hours  in  5  binary hours loaded at edit entry (0-23)
- init_minutes  in  6  binary minutes loaded at edit entry (0-59)
- inc_button  in  1  debounced single-cycle pulse; increments the selected digit
- next_button  in  1  debounced single-cycle pulse; advances the cursor
- hours_left  out  2  hours tens digit, 0-2
- hours_right  out  4  hours units digit, 0-9
- minutes_left  out  3  minutes tens digit, 0-5
- minutes_right  out  4  minutes units digit, 0-9
- hours_bin  out  5  combinational hours_left*10 + hours_right
- minutes_bin  out  6  combinational minutes_left*10 + minutes_right
- digit_sel  out  2  cursor: 0 = HL, 1 = HR, 2 = ML, 3 = MR
- blink  out  1  blink phase for the selected digit
- ack_flag  out  1  editing complete; the value is valid
- load_pulse  out  1  one-cycle strobe when the value is committed

## Operation
- States: IDLE, EDIT_HL, EDIT_HR, EDIT_ML, EDIT_MR, DONE.
- Reset values:
  - state = IDLE
  - all digits = 0
  - digit_sel = 0, blink = 0, ack_flag = 0, load_pulse = 0
  - edit_en_d (registered copy of edit_en) = 0
  - blink counter = 0
- IDLE:
  - Digits hold their values. digit_sel = 0, blink = 0, ack_flag = 0.
  - On a cycle with edit_en = 1 and edit_en_d = 0, the digits load from init_hours and init_minutes (tens = value / 10, units = value % 10) and the state moves to EDIT_HL.
  - If init_hours > 23 or init_minutes > 59, both fields load as 00.
- Any state with edit_en = 0: go to IDLE next cycle, digits held, ack_flag cleared. This takes priority over all other events.
- inc_button in the EDIT states:
  - HL: 0 → 1 → 2 → 0. When HL becomes 2 and HR > 3, HR is forced to 3 in the same cycle.
  - HR: wraps 9 → 0 when HL < 2, and 3 → 0 when HL = 2.
  - ML: wraps 5 → 0.
  - MR: wraps 9 → 0.
- next_button: HL → HR → ML → MR → DONE. In DONE, next_button returns to EDIT_HL and clears ack_flag.
- inc_button and next_button in the same cycle: next_button wins; the increment is discarded.
- DONE:
  - ack_flag = 1, digit_sel = 0, blink = 0.
  - inc_button is ignored.
  - load_pulse is high only in the first cycle of DONE.
- Blink:
  - In the EDIT states, the counter runs 0 … BLINK_DIV-1. blink toggles on each wrap.
  - Counter and blink clear to 0 on entry to EDIT_HL and on every cursor advance.
  - Outside the EDIT states, the counter is held at 0.
- Arithmetic: the digits never leave their legal ranges. hours_bin is 5 bits (max 23) and minutes_bin is 6 bits (max 59), so neither overflows.

## Timing
- All outputs except hours_bin and minutes_bin are registered.
- Button effects are visible in the cycle after the pulse.
- Edit entry: the rising edge of edit_en is sampled in cycle N. Loaded digits and state EDIT_HL are visible in N+1.
- The final next_button from EDIT_MR in cycle N gives ack_flag = 1 and load_pulse = 1 in N+1, and load_pulse = 0 from N+2 onward.
- edit_en dropping in cycle N gives ack_flag = 0 and state IDLE in N+1.
- A held edit_en does not reload. A reload requires edit_en to fall and rise again.
- rst asserted mid-edit overrides everything; the reset values apply in the next cycle.

## Test plan
- Reset, then edit_en rises with init 13:47 → next cycle: HL = 1, HR = 3, ML = 4, MR = 7, digit_sel = 0, ack_flag = 0.
- Init 19:00, inc_button once in EDIT_HL → HL = 2, HR = 3 (forced), hours_bin = 23. Then next_button, inc_button → HR = 0.
- From 00:00: next_button three times, then inc_button ten times → MR returns to 0. Next, next_button → ack_flag = 1, load_pulse high for exactly one cycle, minutes_bin = 0.
- inc_button and next_button pulsed in the same cycle while in EDIT_ML with ML = 5 → digit_sel = 3, ML stays 5.
- Init 25:70 → loads 00:00. With BLINK_DIV = 4, blink toggles every 4 cycles in EDIT_HL, and the counter restarts on next_button.
- Drop edit_en during EDIT_HR → IDLE next cycle, digits held, ack_flag = 0. rst pulsed while in DONE → all outputs 0 next cycle.
